// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encoding, load opcodes and bus layout for the memory stage.
// EX->MEM bus is also exposed as a packed struct so field access stays readable.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 80;
  localparam int MEM_TO_WB_WD = 70;
  localparam int HILO_WD      = 66;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LBU  = 4'd2;
  localparam logic [3:0] MEM_LH   = 4'd3;
  localparam logic [3:0] MEM_LHU  = 4'd4;
  localparam logic [3:0] MEM_LW   = 4'd5;

  // EX->MEM field offsets (LSB positions)
  localparam int EM_MEM_OP_LSB  = 76;
  localparam int EM_PC_LSB      = 44;
  localparam int EM_RAM_EN      = 43;
  localparam int EM_RAM_WEN_LSB = 39;
  localparam int EM_SEL_RF_RES  = 38;
  localparam int EM_RF_WE       = 37;
  localparam int EM_RF_WADDR_LSB = 32;
  localparam int EM_RESULT_LSB  = 0;

  // MEM->WB field offsets
  localparam int MW_PC_LSB       = 38;
  localparam int MW_RF_WE        = 37;
  localparam int MW_RF_WADDR_LSB = 32;
  localparam int MW_RF_WDATA_LSB = 0;

  // HI/LO field offsets
  localparam int HL_HI_WDATA_LSB = 34;
  localparam int HL_LO_WDATA_LSB = 2;
  localparam int HL_HI_WE        = 1;
  localparam int HL_LO_WE        = 0;

  typedef struct packed {
    logic [3:0]  mem_op;
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEM_LB) && (op <= MEM_LW);
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Byte/halfword lane select with sign or zero extension for loads.
// Purely combinational; unknown opcodes produce zero.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // addr[0] is deliberately ignored for halfwords: misalignment is not trapped here
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = 32'h0;
    case (mem_op)
      MEM_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: data = {24'h0, byte_sel};
      MEM_LH:  data = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: data = {16'h0, half_sel};
      MEM_LW:  data = rdata;
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers EX->MEM and HI/LO buses under the stall vector,
// aligns load data (combinational from SRAM) and keeps it stable across stalls.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [HILO_WD-1:0]      hilo_ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [HILO_WD-1:0]      hilo_mem_to_wb_bus,
  output logic                    mem_wreg,
  output logic [4:0]              mem_waddr,
  output logic [31:0]             mem_wdata,
  output logic                    mem_hi_we,
  output logic                    mem_lo_we,
  output logic [31:0]             mem_hi_wdata,
  output logic [31:0]             mem_lo_wdata
);

  ex_mem_t              bus_q, bus_d;
  logic [HILO_WD-1:0]   hilo_q, hilo_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [31:0]          rdata_hold_q, rdata_hold_d;
  logic                 fresh_q, fresh_d;

  logic [31:0]          eff_rdata;
  logic [31:0]          load_data;
  logic [31:0]          rf_wdata;

  always_comb begin
    bus_d        = bus_q;
    hilo_d       = hilo_q;
    hold_valid_d = hold_valid_q;
    rdata_hold_d = rdata_hold_q;
    fresh_d      = 1'b0;
    if (stall[3] == STOP && stall[4] == NO_STOP) begin
      bus_d        = '0;
      hilo_d       = '0;
      hold_valid_d = 1'b0;
    end else if (stall[3] == NO_STOP) begin
      bus_d        = ex_mem_t'(ex_to_mem_bus);
      hilo_d       = hilo_ex_to_mem_bus;
      hold_valid_d = 1'b0;
      fresh_d      = 1'b1;
    end else begin
      // SRAM data is only valid in the first MEM cycle, so grab it before it is lost
      if (fresh_q && !hold_valid_q && bus_q.ram_en && (bus_q.ram_wen == 4'h0)) begin
        hold_valid_d = 1'b1;
        rdata_hold_d = data_sram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q        <= '0;
      hilo_q       <= '0;
      hold_valid_q <= 1'b0;
      rdata_hold_q <= 32'h0;
      fresh_q      <= 1'b0;
    end else begin
      bus_q        <= bus_d;
      hilo_q       <= hilo_d;
      hold_valid_q <= hold_valid_d;
      rdata_hold_q <= rdata_hold_d;
      fresh_q      <= fresh_d;
    end
  end

  assign eff_rdata = hold_valid_q ? rdata_hold_q : data_sram_rdata;

  load_align u_load_align (
    .mem_op (bus_q.mem_op),
    .addr   (bus_q.ex_result[1:0]),
    .rdata  (eff_rdata),
    .data   (load_data)
  );

  assign rf_wdata = (bus_q.sel_rf_res && is_load(bus_q.mem_op)) ? load_data : bus_q.ex_result;

  assign mem_to_wb_bus      = {bus_q.pc, bus_q.rf_we, bus_q.rf_waddr, rf_wdata};
  assign hilo_mem_to_wb_bus = hilo_q;

  assign mem_wreg  = bus_q.rf_we;
  assign mem_waddr = bus_q.rf_waddr;
  assign mem_wdata = rf_wdata;

  assign mem_hi_we    = hilo_q[HL_HI_WE];
  assign mem_lo_we    = hilo_q[HL_LO_WE];
  assign mem_hi_wdata = hilo_q[HL_HI_WDATA_LSB +: 32];
  assign mem_lo_wdata = hilo_q[HL_LO_WDATA_LSB +: 32];

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load extension, held load data, bubbles and HI/LO pass-through.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [79:0] ex_to_mem_bus;
  logic [65:0] hilo_ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [65:0] hilo_mem_to_wb_bus;
  logic        mem_wreg;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_hi_we;
  logic        mem_lo_we;
  logic [31:0] mem_hi_wdata;
  logic [31:0] mem_lo_wdata;

  int errors = 0;
  int checks = 0;

  mem_stage dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .ex_to_mem_bus      (ex_to_mem_bus),
    .hilo_ex_to_mem_bus (hilo_ex_to_mem_bus),
    .data_sram_rdata    (data_sram_rdata),
    .mem_to_wb_bus      (mem_to_wb_bus),
    .hilo_mem_to_wb_bus (hilo_mem_to_wb_bus),
    .mem_wreg           (mem_wreg),
    .mem_waddr          (mem_waddr),
    .mem_wdata          (mem_wdata),
    .mem_hi_we          (mem_hi_we),
    .mem_lo_we          (mem_lo_we),
    .mem_hi_wdata       (mem_hi_wdata),
    .mem_lo_wdata       (mem_lo_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [79:0] mk(input logic [3:0] op, input logic [31:0] pc,
                                     input logic ren, input logic [3:0] wen,
                                     input logic sel, input logic we,
                                     input logic [4:0] wa, input logic [31:0] res);
    return {op, pc, ren, wen, sel, we, wa, res};
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stall = 6'b000000;
    ex_to_mem_bus = '0;
    hilo_ex_to_mem_bus = '0;
    data_sram_rdata = 32'h0;

    // reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    chk("rst_bus", mem_to_wb_bus, 70'h0);
    chk("rst_hilo", hilo_mem_to_wb_bus, 70'h0);
    chk("rst_wreg", mem_wreg, 1'b0);

    // lb, lane 3
    ex_to_mem_bus = mk(4'd1, 32'h100, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'h1003);
    cyc();
    data_sram_rdata = 32'h80FF_1234;
    #1;
    chk("lb_wdata", mem_to_wb_bus[31:0], 32'hFFFF_FF80);
    chk("lb_wreg", mem_wreg, 1'b1);
    chk("lb_waddr", mem_waddr, 5'd3);
    chk("lb_pc", mem_to_wb_bus[69:38], 32'h100);

    ex_to_mem_bus = mk(4'd2, 32'h104, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'h1003);
    cyc();
    #1;
    chk("lbu_wdata", mem_to_wb_bus[31:0], 32'h0000_0080);

    ex_to_mem_bus = mk(4'd1, 32'h108, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'h1000);
    cyc();
    #1;
    chk("lb_lane0", mem_to_wb_bus[31:0], 32'h0000_0034);

    // halfwords
    ex_to_mem_bus = mk(4'd3, 32'h10C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h2002);
    cyc();
    data_sram_rdata = 32'h9ABC_0001;
    #1;
    chk("lh_wdata", mem_to_wb_bus[31:0], 32'hFFFF_9ABC);

    ex_to_mem_bus = mk(4'd3, 32'h110, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h2003);
    cyc();
    #1;
    chk("lh_odd", mem_to_wb_bus[31:0], 32'hFFFF_9ABC);

    ex_to_mem_bus = mk(4'd4, 32'h114, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h2000);
    cyc();
    #1;
    chk("lhu_wdata", mem_to_wb_bus[31:0], 32'h0000_0001);

    // unused opcode behaves as no load
    ex_to_mem_bus = mk(4'd6, 32'h118, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h5555);
    cyc();
    #1;
    chk("op6_wdata", mem_to_wb_bus[31:0], 32'h0000_5555);

    // HI/LO pass-through
    ex_to_mem_bus = mk(4'd0, 32'h200, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7, 32'h42);
    hilo_ex_to_mem_bus = {32'h1111_2222, 32'h3333_4444, 1'b1, 1'b1};
    cyc();
    #1;
    chk("hilo_bus", hilo_mem_to_wb_bus, {4'h0, 32'h1111_2222, 32'h3333_4444, 1'b1, 1'b1});
    chk("hi_wdata", mem_hi_wdata, 32'h1111_2222);
    chk("lo_wdata", mem_lo_wdata, 32'h3333_4444);
    chk("hilo_we", {mem_hi_we, mem_lo_we}, 2'b11);

    // held load across a 3-cycle stall
    ex_to_mem_bus = mk(4'd5, 32'h300, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h3000);
    hilo_ex_to_mem_bus = '0;
    cyc();
    data_sram_rdata = 32'hDEAD_BEEF;
    stall = 6'b011000;
    #1;
    chk("lw_first", mem_to_wb_bus[31:0], 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      cyc();
      data_sram_rdata = 32'h0;
      #1;
      chk("lw_held", mem_to_wb_bus[31:0], 32'hDEAD_BEEF);
    end
    chk("lw_held_pc", mem_to_wb_bus[69:38], 32'h300);

    // bubble
    ex_to_mem_bus = mk(4'd0, 32'h400, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h99);
    hilo_ex_to_mem_bus = {32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b1};
    stall = 6'b001000;
    cyc();
    #1;
    chk("bub_wreg", mem_wreg, 1'b0);
    chk("bub_hilo_we", {mem_hi_we, mem_lo_we}, 2'b00);
    chk("bub_bus", mem_to_wb_bus, 70'h0);

    // fresh load after bubble sees live SRAM data
    stall = 6'b000000;
    hilo_ex_to_mem_bus = '0;
    ex_to_mem_bus = mk(4'd5, 32'h500, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h5000);
    cyc();
    data_sram_rdata = 32'h1122_3344;
    stall = 6'b011000;
    #1;
    chk("lw2_live", mem_to_wb_bus[31:0], 32'h1122_3344);
    cyc();
    data_sram_rdata = 32'h0;
    #1;
    chk("lw2_held", mem_to_wb_bus[31:0], 32'h1122_3344);

    // reset while holding
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_mid_bus", mem_to_wb_bus, 70'h0);
    stall = 6'b000000;
    ex_to_mem_bus = mk(4'd5, 32'h600, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h6000);
    cyc();
    data_sram_rdata = 32'h5566_7788;
    #1;
    chk("lw3_live", mem_to_wb_bus[31:0], 32'h5566_7788);

    // store: no capture, wdata is ex_result
    ex_to_mem_bus = mk(4'd0, 32'h700, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h100);
    cyc();
    data_sram_rdata = 32'hCAFE_0000;
    stall = 6'b011000;
    #1;
    chk("sw_wdata", mem_to_wb_bus[31:0], 32'h0000_0100);
    cyc();
    data_sram_rdata = 32'h0;
    #1;
    chk("sw_stall_wdata", mem_to_wb_bus[31:0], 32'h0000_0100);
    chk("sw_wreg", mem_wreg, 1'b0);

    // ALU op after the store
    stall = 6'b000000;
    ex_to_mem_bus = mk(4'd0, 32'h704, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'h1234);
    cyc();
    #1;
    chk("alu_wdata", mem_to_wb_bus[31:0], 32'h0000_1234);
    chk("alu_fwd", mem_wdata, 32'h0000_1234);
    chk("alu_waddr", mem_waddr, 5'd9);
    chk("alu_wreg", mem_wreg, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
